// File: rtl/fp_pkg.sv
// Shared definitions for the float-to-integer converter.
//   EXP_BIAS, EXP_SPECIAL, MANT_W : IEEE-754 single-precision field constants
//   INT_MAX, INT_MIN              : saturation values of the 32-bit signed result
//   state_t                       : converter FSM states
//   fp_class_t                    : operand classification produced by fp_unpack
package fp_pkg;

    localparam int unsigned EXP_BIAS    = 127;
    localparam logic [7:0]  EXP_SPECIAL = 8'hFF;
    localparam int unsigned MANT_W      = 23;
    localparam logic [31:0] INT_MAX     = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN     = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        SHIFT,
        SIGN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        FP_ZERO,
        FP_DENORM,
        FP_NORMAL,
        FP_INF,
        FP_NAN
    } fp_class_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational field splitter and classifier for an IEEE-754 single.
//   fp       in  32  operand
//   sign     out 1   fp[31]
//   exponent out 8   fp[30:23]
//   mantissa out 23  fp[22:0]
//   cls      out     zero / denormal / normal / inf / NaN
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0]       fp,
    output logic              sign,
    output logic [7:0]        exponent,
    output logic [MANT_W-1:0] mantissa,
    output fp_class_t         cls
);

    always_comb begin
        sign     = fp[31];
        exponent = fp[30:23];
        mantissa = fp[22:0];
        cls      = FP_NORMAL;
        if (exponent == EXP_SPECIAL) begin
            cls = (mantissa != '0) ? FP_NAN : FP_INF;
        end else if (exponent == 8'h00) begin
            cls = (mantissa != '0) ? FP_DENORM : FP_ZERO;
        end
    end

endmodule

// File: rtl/fp_to_int.sv
// Multi-cycle IEEE-754 single to 32-bit signed integer converter (truncating).
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake, fp captured on accept
//   fp                   IEEE-754 single operand
//   out_valid/out_ready  result handshake
//   intgr                two's-complement result
//   overflow/invalid/inexact  status flags, valid with out_valid
module fp_to_int
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] fp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] intgr,
    output logic        overflow,
    output logic        invalid,
    output logic        inexact
);

    state_t state, state_next;

    logic [31:0] fp_q, mag_q, intgr_q;
    logic [4:0]  cnt_q;
    logic        left_q, special_q, sticky_q, ovf_q, inv_q;
    logic        out_valid_q, overflow_q, invalid_q, inexact_q;

    logic              sign;
    logic [7:0]        exponent;
    logic [MANT_W-1:0] mantissa;
    fp_class_t         cls;

    fp_unpack u_unpack (
        .fp       (fp_q),
        .sign     (sign),
        .exponent (exponent),
        .mantissa (mantissa),
        .cls      (cls)
    );

    // Unbiased exponent and the classification decided during UNPACK
    logic signed [9:0] e_s, diff;
    logic [31:0]       up_val;
    logic [4:0]        up_n;
    logic              up_special, up_left, up_ovf, up_inv, up_inx;

    assign e_s = $signed({2'b00, exponent}) - $signed(10'(EXP_BIAS));

    always_comb begin
        up_special = 1'b1;
        up_val     = '0;
        up_n       = '0;
        up_left    = 1'b0;
        up_ovf     = 1'b0;
        up_inv     = 1'b0;
        up_inx     = 1'b0;
        diff       = '0;
        if (cls == FP_NAN) begin
            up_inv = 1'b1;
            up_val = INT_MIN;
        end else if (cls == FP_INF) begin
            up_inv = 1'b1;
            up_val = sign ? INT_MIN : INT_MAX;
        end else if (cls == FP_ZERO || cls == FP_DENORM || e_s < 10'sd0) begin
            up_inx = |fp_q[30:0];
        end else if (e_s >= 10'sd31) begin
            // -2^31 is the one e=31 value that is representable
            if (fp_q == 32'hCF00_0000) begin
                up_val = INT_MIN;
            end else begin
                up_ovf = 1'b1;
                up_val = sign ? INT_MIN : INT_MAX;
            end
        end else begin
            up_special = 1'b0;
            up_val     = {8'b0, 1'b1, mantissa};
            up_left    = e_s > 10'sd23;
            diff       = up_left ? (e_s - 10'sd23) : (10'sd23 - e_s);
            up_n       = diff[4:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = UNPACK;
            UNPACK:  state_next = (!up_special && up_n != 5'd0) ? SHIFT : SIGN;
            SHIFT:   if (cnt_q == 5'd1) state_next = SIGN;
            SIGN:    state_next = DONE;
            // First DONE cycle registers the result; exit only once it has been offered
            DONE:    if (out_valid_q && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fp_q        <= '0;
            mag_q       <= '0;
            cnt_q       <= '0;
            left_q      <= 1'b0;
            special_q   <= 1'b0;
            sticky_q    <= 1'b0;
            ovf_q       <= 1'b0;
            inv_q       <= 1'b0;
            out_valid_q <= 1'b0;
            intgr_q     <= '0;
            overflow_q  <= 1'b0;
            invalid_q   <= 1'b0;
            inexact_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) fp_q <= fp;
                UNPACK: begin
                    mag_q     <= up_val;
                    cnt_q     <= up_n;
                    left_q    <= up_left;
                    special_q <= up_special;
                    ovf_q     <= up_ovf;
                    inv_q     <= up_inv;
                    sticky_q  <= up_inx;
                end
                SHIFT: begin
                    if (left_q) begin
                        mag_q <= mag_q << 1;
                    end else begin
                        mag_q    <= mag_q >> 1;
                        sticky_q <= sticky_q | mag_q[0];
                    end
                    cnt_q <= cnt_q - 5'd1;
                end
                // Special results already carry their final sign
                SIGN: if (!special_q && fp_q[31]) mag_q <= ~mag_q + 32'd1;
                DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        intgr_q     <= mag_q;
                        overflow_q  <= ovf_q;
                        invalid_q   <= inv_q;
                        inexact_q   <= sticky_q;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = out_valid_q;
    assign intgr     = intgr_q;
    assign overflow  = overflow_q;
    assign invalid   = invalid_q;
    assign inexact   = inexact_q;

endmodule

// File: tb/tb_fp_to_int.sv
module tb_fp_to_int;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] fp = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] intgr;
    logic        overflow, invalid, inexact;

    fp_to_int dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fp        (fp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .intgr     (intgr),
        .overflow  (overflow),
        .invalid   (invalid),
        .inexact   (inexact)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] val;
        logic        ovf, inv, inx;
        int          lat, acc, stall;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Drive one operand at a negedge; it is accepted on the following posedge
    task automatic send(input logic [31:0] f, input logic [31:0] v, input logic o, input logic i,
                        input logic x, input int lat, input int stall, input bit push);
        exp_t e;
        int   budget;
        budget = 0;
        @(negedge clk);
        while (!in_ready && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
            return;
        end
        in_valid = 1'b1;
        fp       = f;
        e.val = v; e.ovf = o; e.inv = i; e.inx = x;
        e.lat = lat; e.acc = cyc + 1; e.stall = stall;
        if (push) sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        fp       = 32'hDEAD_BEEF;
    endtask

    // Monitor: pops expectations on each new result and checks handshake behaviour
    bit          prev_valid = 1'b0;
    bit          prev_hs = 1'b0;
    int          stall_left = 0;
    logic [31:0] held = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
            stall_left = 0;
            out_ready  = 1'b1;
        end else begin
            if (prev_hs) begin
                check("release_out_valid", {31'b0, out_valid}, 32'd0);
                check("release_in_ready", {31'b0, in_ready}, 32'd1);
            end else if (prev_valid) begin
                check("hold_out_valid", {31'b0, out_valid}, 32'd1);
                check("hold_intgr", intgr, held);
                check("hold_in_ready", {31'b0, in_ready}, 32'd0);
            end
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("intgr", intgr, e.val);
                    check("overflow", {31'b0, overflow}, {31'b0, e.ovf});
                    check("invalid", {31'b0, invalid}, {31'b0, e.inv});
                    check("inexact", {31'b0, inexact}, {31'b0, e.inx});
                    check("latency", 32'(cyc - e.acc), 32'(e.lat));
                    held = e.val;
                    if (e.stall > 0) begin
                        out_ready  = 1'b0;
                        stall_left = e.stall;
                    end
                end
            end else if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) out_ready = 1'b1;
            end
            prev_valid = out_valid;
            prev_hs    = out_valid && out_ready;
        end
    end

    initial begin
        int budget;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_intgr", intgr, 32'd0);
        check("rst_flags", {29'b0, overflow, invalid, inexact}, 32'd0);
        rst = 1'b0;

        //    fp            intgr          ovf   inv   inx   lat stall push
        send(32'h3F80_0000, 32'd1,         1'b0, 1'b0, 1'b0, 26, 0,  1'b1); // 1.0
        send(32'hC2F6_0000, 32'hFFFF_FF85, 1'b0, 1'b0, 1'b0, 20, 10, 1'b1); // -123.0, stalled
        send(32'h3FC0_0000, 32'd1,         1'b0, 1'b0, 1'b1, 26, 0,  1'b1); // 1.5
        send(32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 3,  0,  1'b1); // 2^31
        send(32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 3,  0,  1'b1); // -2^31
        send(32'h7FC0_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 3,  0,  1'b1); // NaN
        send(32'h4B00_0001, 32'd8388609,   1'b0, 1'b0, 1'b0, 3,  0,  1'b1); // e=23
        send(32'h8000_0000, 32'd0,         1'b0, 1'b0, 1'b0, 3,  0,  1'b1); // -0.0
        send(32'h7F80_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 3,  0,  1'b1); // +inf
        send(32'hFF80_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 3,  3,  1'b1); // -inf
        send(32'hBF00_0000, 32'd0,         1'b0, 1'b0, 1'b1, 3,  0,  1'b1); // -0.5
        send(32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 1'b0, 10, 0,  1'b1); // e=30
        send(32'hCEFF_FFFF, 32'h8000_0080, 1'b0, 1'b0, 1'b0, 10, 0,  1'b1); // -(e=30)
        send(32'hC049_0FDB, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b1, 25, 0,  1'b1); // -pi
        send(32'h0000_0001, 32'd0,         1'b0, 1'b0, 1'b1, 3,  0,  1'b1); // denormal
        send(32'h3F7F_FFFF, 32'd0,         1'b0, 1'b0, 1'b1, 3,  0,  1'b1); // just below 1

        // Interrupt a conversion of 1.0 mid-shift; it must never produce a result
        send(32'h3F80_0000, 32'd1, 1'b0, 1'b0, 1'b0, 26, 0, 1'b0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_intgr", intgr, 32'd0);
        repeat (30) @(negedge clk);
        send(32'h3F80_0000, 32'd1,         1'b0, 1'b0, 1'b0, 26, 0,  1'b1);
        send(32'h4B00_0001, 32'd8388609,   1'b0, 1'b0, 1'b0, 3,  0,  1'b1);

        budget = 0;
        while ((sb.size() != 0 || out_valid) && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        if (sb.size() != 0 || out_valid) check("drain_timeout", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
